// File: rtl/bcd2bin_pkg.sv
// bcd2bin_pkg: shared constants, state encoding and helpers for the
// sequential BCD-to-binary converter (bcd2bin_seq, bcd_digit_corr).
`timescale 1ns/1ps
package bcd2bin_pkg;

  localparam int DIGITS_DEF = 3;   // default BCD digit count
  localparam int BIN_W_DEF  = 10;  // default result width == shift-step count
  localparam int DIG_W      = 4;   // bits per BCD digit

  localparam logic [DIG_W-1:0] CORR_TH  = 4'd8;  // digit >= this gets corrected
  localparam logic [DIG_W-1:0] CORR_VAL = 4'd3;  // amount subtracted on correction
  localparam logic [DIG_W-1:0] DIG_MAX  = 4'd9;  // largest legal BCD digit

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic digit_invalid(input logic [DIG_W-1:0] d);
    return d > DIG_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_corr.sv
// bcd_digit_corr: combinational reverse double-dabble digit correction.
// After the right shift a digit that reads 8 or more has received a carry-in
// worth 8 from the digit above, which in decimal is worth only 5, so 3 is
// removed. The result is always >= 5, so no underflow.
// Ports:
//   dig_i  4-bit digit taken from the shifted working register
//   dig_o  corrected digit
`timescale 1ns/1ps
module bcd_digit_corr
  import bcd2bin_pkg::*;
(
  input  logic [DIG_W-1:0] dig_i,
  output logic [DIG_W-1:0] dig_o
);

  assign dig_o = (dig_i >= CORR_TH) ? (dig_i - CORR_VAL) : dig_i;

endmodule

// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: sequential BCD-to-binary converter, one shift step per clock
// (shift right, subtract 3 from every BCD digit >= 8).
// Optional feature macro: BCD2BIN_ERR_CHECK_EN -- when defined, an operand
// containing a digit above 9 skips the shift phase and completes next cycle
// with oBIN=0, oERR=1. When undefined, oERR is tied low.
// Ports:
//   iCLK    clock, rising edge
//   iRST_N  asynchronous active-low reset
//   iSTART  conversion request, only honoured in IDLE
//   iBCD    packed BCD operand, digit 0 in [3:0], captured on accept
//   oBIN    registered binary result, held until the next oDONE
//   oBUSY   high whenever not IDLE
//   oDONE   one-cycle completion pulse (oBIN/oERR valid)
//   oERR    invalid-digit flag, held with oBIN
`timescale 1ns/1ps
module bcd2bin_seq
  import bcd2bin_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int BIN_W  = BIN_W_DEF
) (
  input  logic                    iCLK,
  input  logic                    iRST_N,
  input  logic                    iSTART,
  input  logic [DIG_W*DIGITS-1:0] iBCD,
  output logic [BIN_W-1:0]        oBIN,
  output logic                    oBUSY,
  output logic                    oDONE,
  output logic                    oERR
);

  localparam int BCD_W = DIG_W * DIGITS;
  localparam int WW    = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

  state_e                       state_q, state_d;
  logic [WW-1:0]                w_q, w_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [BIN_W-1:0]             bin_q, bin_d;

  logic [WW-1:0]                w_shr, w_step;
  logic [DIGITS-1:0][DIG_W-1:0] corr;
  logic                         bcd_bad;

  // One reverse double-dabble step: shift, then correct each BCD digit.
  assign w_shr = w_q >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_corr
    bcd_digit_corr u_corr (
      .dig_i (w_shr[BIN_W + g*DIG_W +: DIG_W]),
      .dig_o (corr[g])
    );
  end

  assign w_step = {corr, w_shr[BIN_W-1:0]};

`ifdef BCD2BIN_ERR_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    bcd_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      bcd_bad = bcd_bad | digit_invalid(iBCD[i*DIG_W +: DIG_W]);
  end
`else
  assign bcd_bad = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
`ifdef BCD2BIN_ERR_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (iSTART) begin
          if (bcd_bad) begin
            // Bad operand: report immediately, nothing to convert.
            state_d = DONE;
            bin_d   = '0;
`ifdef BCD2BIN_ERR_CHECK_EN
            err_d   = 1'b1;
`endif
          end else begin
            state_d = SHIFT;
            w_d     = {iBCD, {BIN_W{1'b0}}};
            cnt_d   = '0;
          end
        end
      end
      SHIFT: begin
        w_d   = w_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          state_d = DONE;
          bin_d   = w_step[BIN_W-1:0];
`ifdef BCD2BIN_ERR_CHECK_EN
          err_d   = 1'b0;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= IDLE;
      w_q     <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
`ifdef BCD2BIN_ERR_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
`ifdef BCD2BIN_ERR_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign oBIN  = bin_q;
  assign oBUSY = (state_q != IDLE);
  assign oDONE = (state_q == DONE);
`ifdef BCD2BIN_ERR_CHECK_EN
  assign oERR  = err_q;
`else
  assign oERR  = 1'b0;
`endif

endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb_bcd2bin_seq: self-checking bench for bcd2bin_seq. A cycle-level
// behavioural model (remaining-busy-cycles counter plus decimal arithmetic)
// is compared against the DUT on every falling edge; directed sequences add
// literal latency/value expectations.
`timescale 1ns/1ps
module tb_bcd2bin_seq;
  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;
`ifdef BCD2BIN_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic                  iCLK = 1'b0;
  logic                  iRST_N = 1'b0;
  logic                  iSTART = 1'b0;
  logic [4*DIGITS-1:0]   iBCD = '0;
  logic [BIN_W-1:0]      oBIN;
  logic                  oBUSY, oDONE, oERR;

  bcd2bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iSTART(iSTART), .iBCD(iBCD),
    .oBIN(oBIN), .oBUSY(oBUSY), .oDONE(oDONE), .oERR(oERR)
  );

  always #5 iCLK = ~iCLK;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int bcd_val(input logic [4*DIGITS-1:0] b);
    int v = 0;
    for (int i = DIGITS-1; i >= 0; i--) v = v*10 + int'(b[i*4 +: 4]);
    return v;
  endfunction

  function automatic bit bcd_ok(input logic [4*DIGITS-1:0] b);
    for (int i = 0; i < DIGITS; i++) if (b[i*4 +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] b = '0;
    int t = v;
    for (int i = 0; i < DIGITS; i++) begin
      b[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return b;
  endfunction

  // ---- behavioural model ----
  // rem = cycles still to spend busy; the last busy cycle is the done cycle.
  int rem = 0;
  int p_bin = 0, m_bin = 0;
  bit p_err = 0, m_err = 0;
  bit p_known = 1, m_known = 1;

  always @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      rem = 0; m_bin = 0; m_err = 0; m_known = 1;
    end else begin
      if (rem == 0) begin
        if (iSTART === 1'b1) begin
          if (!bcd_ok(iBCD) && ERR_EN) begin
            rem = 1; p_bin = 0; p_err = 1; p_known = 1;
          end else begin
            rem = BIN_W + 1;
            p_bin = bcd_val(iBCD); p_err = 0; p_known = bcd_ok(iBCD);
          end
        end
      end else begin
        rem--;
      end
      if (rem == 1) begin
        m_bin = p_bin; m_err = p_err; m_known = p_known;
      end
    end
  end

  always @(negedge iCLK) begin
    chk("busy", oBUSY, rem != 0);
    chk("done", oDONE, rem == 1);
    chk("err",  oERR,  m_err);
    if (m_known) chk("bin", oBIN, m_bin);
  end

  // ---- directed helpers ----
  // Wait until idle (checked just after a rising edge), then request; returns
  // #1 after the accepting edge with iSTART still as 'hold' leaves it.
  task automatic start(input logic [4*DIGITS-1:0] bcd, input bit hold);
    int n = 0;
    @(posedge iCLK); #1;
    while (oBUSY !== 1'b0 && n < 100) begin @(posedge iCLK); #1; n++; end
    if (n >= 100) chk("idle_timeout", n, 0);
    iSTART = 1'b1; iBCD = bcd;
    @(posedge iCLK); #1;
    if (!hold) iSTART = 1'b0;
  endtask

  // Counts edges from the accepting edge (inclusive) to the one after which
  // oDONE is seen; returns at the falling edge inside the done cycle.
  task automatic wait_done(output int lat);
    lat = 1;
    @(negedge iCLK);
    while (oDONE !== 1'b1 && lat < 40) begin @(posedge iCLK); @(negedge iCLK); lat++; end
  endtask

  task automatic run_one(input logic [4*DIGITS-1:0] bcd, input int exp_bin,
                         input bit exp_err, input int exp_lat, input bit chkbin);
    int lat;
    start(bcd, 1'b0);
    wait_done(lat);
    chk("latency", lat, exp_lat);
    chk("done_pulse", oDONE, 1);
    if (chkbin) chk("result", oBIN, exp_bin);
    chk("err_flag", oERR, exp_err);
  endtask

  initial begin
    int lat, ndone;
    logic [4*DIGITS-1:0] b;

    // reset state
    repeat (2) @(posedge iCLK);
    #1;
    chk("rst_bin", oBIN, 0); chk("rst_busy", oBUSY, 0);
    chk("rst_done", oDONE, 0); chk("rst_err", oERR, 0);
    iRST_N = 1'b1;

    // first conversion: 999 -> 0x3E7, 11-edge latency
    run_one(12'h999, 32'h3E7, 1'b0, 11, 1'b1);

    // back-to-back sweep of every valid operand
    for (int v = 0; v < 1000; v++) run_one(to_bcd(v), v, 1'b0, 11, 1'b1);

    // iSTART held with a changing operand: no queueing, new one only from IDLE
    start(12'h255, 1'b1);
    iBCD = 12'h111;
    wait_done(lat);
    chk("hold_lat", lat, 11); chk("hold_bin", oBIN, 255);
    @(posedge iCLK);             // DONE -> IDLE, start ignored here
    @(posedge iCLK); #1;         // first IDLE edge accepts 111
    iSTART = 1'b0;
    chk("hold_busy2", oBUSY, 1);
    wait_done(lat);
    chk("hold2_lat", lat, 11); chk("hold2_bin", oBIN, 111);

    // asynchronous reset in the middle of SHIFT
    start(12'h640, 1'b0);
    repeat (4) @(posedge iCLK);
    #2 iRST_N = 1'b0;
    #1;
    chk("arst_bin", oBIN, 0); chk("arst_busy", oBUSY, 0);
    chk("arst_done", oDONE, 0); chk("arst_err", oERR, 0);
    @(posedge iCLK); #2 iRST_N = 1'b1;
    ndone = 0;
    repeat (15) begin @(negedge iCLK); if (oDONE === 1'b1) ndone++; end
    chk("arst_no_done", ndone, 0);
    run_one(12'h007, 7, 1'b0, 11, 1'b1);

    // invalid digit
    if (ERR_EN) run_one(12'h1A3, 0, 1'b1, 1, 1'b1);
    else        run_one(12'h1A3, 0, 1'b0, 11, 1'b0);
    run_one(12'h100, 100, 1'b0, 11, 1'b1);

    // randomized traffic, occasional invalid digits; model checks every cycle
    for (int c = 0; c < 3000; c++) begin
      @(posedge iCLK); #1;
      iSTART = ($urandom_range(0, 2) == 0);
      b = '0;
      for (int d = 0; d < DIGITS; d++)
        b[d*4 +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                   : 4'($urandom_range(0, 9));
      iBCD = b;
    end
    @(posedge iCLK); #1 iSTART = 1'b0;
    repeat (20) @(posedge iCLK);
    @(negedge iCLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
